// File: rtl/led_pkg.sv
// rtl/led_pkg.sv - shared constants and mode helpers for the LED pattern front end
package led_pkg;

    localparam int NUM_BTN = 4;
    localparam int LED_W   = 12;

    typedef logic [3:0] mode_t;

    localparam mode_t MODE_STOP   = 4'b0000;
    localparam mode_t MODE_LR     = 4'b0001;
    localparam mode_t MODE_INV    = 4'b0010;
    localparam mode_t MODE_CENTER = 4'b0100;

    // Button 3 always means stop; otherwise the lowest-index active button wins.
    function automatic mode_t btn_to_mode(input logic [NUM_BTN-1:0] btn);
        if (btn[3])      return MODE_STOP;
        else if (btn[0]) return MODE_LR;
        else if (btn[1]) return MODE_INV;
        else if (btn[2]) return MODE_CENTER;
        else             return MODE_STOP;
    endfunction

endpackage

// File: rtl/led_mode_ctrl_if.sv
// rtl/led_mode_ctrl_if.sv - button inputs and mode/step outputs of the LED control stage
interface led_mode_ctrl_if;
    import led_pkg::*;

    logic [NUM_BTN-1:0] btn_n;
    mode_t              mode;
    logic               mode_chg;
    logic               step;

    modport master (output btn_n, input mode, mode_chg, step);
    modport slave  (input btn_n, output mode, mode_chg, step);

endinterface

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - two-flop synchroniser, level debounce and press-edge detect for one button
module btn_debounce #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n_i,
    output logic stb_o,
    output logic press_o
);

    localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             press_sync;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             stb_q, stb_d;
    logic             stb_dly_q;

    assign press_sync = ~sync2_q;

    always_comb begin
        cnt_d = cnt_q;
        stb_d = stb_q;
        if (press_sync == stb_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            stb_d = press_sync;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            cnt_q     <= '0;
            stb_q     <= 1'b0;
            stb_dly_q <= 1'b0;
        end else begin
            sync1_q   <= btn_n_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            stb_q     <= stb_d;
            stb_dly_q <= stb_q;
        end
    end

    assign stb_o   = stb_q;
    assign press_o = stb_q & ~stb_dly_q;

endmodule

// File: rtl/led_mode_ctrl.sv
// rtl/led_mode_ctrl.sv - button-to-mode control and step generator; LED_MODE_LATCH_EN selects latched vs level mode
module led_mode_ctrl
    import led_pkg::*;
#(
    parameter int DB_CYCLES   = 1000000,
    parameter int STEP_CYCLES = 2097152
) (
    input  logic            clk,
    input  logic            rst,
    led_mode_ctrl_if.slave  ctrl_if
);

    localparam int SCNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
    localparam logic [SCNT_W-1:0] SCNT_MAX = SCNT_W'(STEP_CYCLES - 1);

    logic [NUM_BTN-1:0] stb;
    logic [NUM_BTN-1:0] press;
    mode_t              mode_q, mode_d;
    logic               mode_chg_q, mode_chg_d;
    logic [SCNT_W-1:0]  scnt_q, scnt_d;
    logic               scnt_wrap;

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
        btn_debounce #(
            .DB_CYCLES (DB_CYCLES)
        ) u_btn_debounce (
            .clk     (clk),
            .rst     (rst),
            .btn_n_i (ctrl_if.btn_n[i]),
            .stb_o   (stb[i]),
            .press_o (press[i])
        );
    end

`ifdef LED_MODE_LATCH_EN
    logic unused_stb;
    assign unused_stb = ^stb;

    // Releases are ignored: mode holds until the next press event.
    always_comb begin
        mode_d = mode_q;
        if (|press) begin
            mode_d = btn_to_mode(press);
        end
    end
`else
    logic unused_press;
    assign unused_press = ^press;

    always_comb begin
        mode_d = btn_to_mode(stb);
    end
`endif

    assign mode_chg_d = (mode_d != mode_q);

    // A mode change restarts the cadence so the first step lands a full period later.
    assign scnt_wrap = (scnt_q == SCNT_MAX);

    always_comb begin
        scnt_d = scnt_q + 1'b1;
        if (mode_chg_q || scnt_wrap) begin
            scnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_STOP;
            mode_chg_q <= 1'b0;
            scnt_q     <= '0;
        end else begin
            mode_q     <= mode_d;
            mode_chg_q <= mode_chg_d;
            scnt_q     <= scnt_d;
        end
    end

    assign ctrl_if.mode     = mode_q;
    assign ctrl_if.mode_chg = mode_chg_q;
    assign ctrl_if.step     = scnt_wrap && !mode_chg_q && (mode_q != MODE_STOP);

endmodule

// File: doc/led_mode_ctrl.md
# led_mode_ctrl

Front-end control stage for the 12-LED pattern driver. Synchronises and debounces the four active-low push buttons. Turns presses into a clean, latched one-hot mode code, and produces a single-cycle step enable that replaces the ripple-divided pattern clock. The pattern driver consumes `mode`, `mode_chg` and `step` in the `clk` domain.

## Interface
- `DB_CYCLES`, default 1000000: number of consecutive cycles a synchronised button level must differ from its stable value before it is accepted (20 ms at 50 MHz).
- `STEP_CYCLES`, default 2097152: period of `step` in `clk` cycles.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `btn_n`, input, 4: raw push buttons, active-low, asynchronous to `clk`.
- `mode`, output, 4: current mode.
  - 4'b0000 = stop
  - 4'b0001 = left-to-right single dot
  - 4'b0010 = inverted dot
  - 4'b0100 = centre pair
- `mode_chg`, output, 1: one-cycle pulse in the cycle `mode` takes a new value. The driver loads the initial pattern on this pulse.
- `step`, output, 1: one-cycle pattern-advance enable.

## Operation
- **Synchroniser:** two-flop synchroniser per button, then inversion, so `press_sync[i]` is 1 when the button is held.
- **Debounce, per button:**
  - Counter `cnt` and stable level `stb`.
  - If `press_sync` equals `stb`, `cnt` is cleared to 0.
  - Otherwise `cnt` increments.
  - When `cnt` equals `DB_CYCLES-1` and the levels still differ, `stb` takes `press_sync` and `cnt` is cleared to 0.
  - A glitch shorter than `DB_CYCLES` cycles never changes `stb`.
- **Press event:** `press[i] = stb[i] & ~stb_q[i]`, where `stb_q` is `stb` delayed one cycle. Releases generate no event.
- **Mode update:** registered, in the cycle after a press event. Priority, highest first:
  - Button 3 press: `mode` becomes 0.
  - Otherwise the lowest-index press among buttons 0–2: `mode` becomes the one-hot value of that button.
- **Mode change pulse:** `mode_chg` pulses only if the new `mode` differs from the old one. Pressing the active mode's button again does nothing.
- **Step generator:**
  - Counter `scnt` runs 0..`STEP_CYCLES-1` and wraps to 0.
  - `step` is 1 in the cycle `scnt` equals `STEP_CYCLES-1`.
  - When `mode_chg` is 1, `scnt` is forced to 0, so the first `step` after a change comes exactly `STEP_CYCLES` cycles later.
  - `step` is suppressed (0) while `mode` is 0.

## Timing
- **Reset values:**
  - Synchroniser flops: 1 (released).
  - `stb` and `stb_q`: 0; `cnt` and `scnt`: 0.
  - Outputs: `mode` = 0, `mode_chg` = 0, `step` = 0.
- **Press latency:** if `btn_n[i]` falls before clock edge E and stays low, `stb[i]` rises at edge E+1+`DB_CYCLES`. `mode` and `mode_chg` update at edge E+2+`DB_CYCLES`.
- **Reset mid-debounce or mid-step:** all state returns to reset values on the next edge. A button held through reset is re-debounced and produces a press event after release of `rst`.
- **Simultaneous presses:** resolved by the priority rule above within the same cycle. Only one `mode_chg` pulse is produced.
- **Step collision:** if `mode_chg` and the `scnt` wrap occur in the same cycle, `step` is 0 and the counter restarts.
- **Width:** counter widths are `$clog2` of the parameter, minimum 1. `DB_CYCLES` and `STEP_CYCLES` must be at least 2.

## Configuration
- Macro: `LED_MODE_LATCH_EN`.
- **Defined:** the latched behaviour described in Operation.
- **Undefined:** level mode.
  - `mode` follows the debounced levels, one cycle after `stb`: the lowest-index held button among 0–2 gives its one-hot code; none held, or button 3 held, gives 0.
  - `mode_chg` still pulses on every change of `mode`, including returns to 0.

## Structure
- **Shared package `led_pkg`:**
  - Mode constants `MODE_STOP`, `MODE_LR`, `MODE_INV`, `MODE_CENTER`.
  - `NUM_BTN` = 4.
  - `LED_W` = 12, used by the driver.
- **Sub-module `btn_debounce`:** one instance per button, parameterised by `DB_CYCLES`. Contains the synchroniser, counter and `stb`, and outputs `stb` and `press`.
- **Top level:** the priority/mode logic and the step generator.

## Test plan
All scenarios use `DB_CYCLES` = 4 and `STEP_CYCLES` = 8.
1. Hold `btn_n` = 4'b1110 from edge 10 → `mode` = 4'b0001 and `mode_chg` = 1 at edge 16 only. First `step` at edge 24, then every 8 cycles.
2. 3-cycle low glitch on `btn_n[1]` → `stb`, `mode` and `mode_chg` unchanged. A 4-cycle low pulse is accepted and gives `mode` = 4'b0010.
3. `btn_n` = 4'b1010 (buttons 0 and 2 pressed together) → `mode` = 4'b0001 and a single `mode_chg`. Then press button 3 → `mode` = 0 and `step` stays 0.
4. Re-press button 0 while `mode` = 4'b0001 → no `mode_chg`, and the `step` cadence is undisturbed.
5. Assert `rst` for one cycle mid-count, with `scnt` = 5 and `cnt` = 2 → all outputs 0 next edge. A held button yields `mode_chg` 2+`DB_CYCLES` edges after `rst` falls.
6. With `LED_MODE_LATCH_EN` undefined: hold then release button 2 → `mode` = 4'b0100, then 0, with `mode_chg` pulsing on both changes.
